// File: rtl/pipeline_ctrl.sv
// =============================================================================
// Module  : pipeline_ctrl
// Brief   : Five-stage pipeline stall/flush scheduler with wrong-path fetch drop
// Revision: 1.0
// =============================================================================
`default_nettype none

module pipeline_ctrl #(
   parameter int MD_CYCLES = 32
) (
   input  logic clk,
   input  logic reset,
   input  logic redirect_d,
   input  logic load_use_d,
   input  logic imem_busy,
   input  logic imem_resp,
   input  logic dmem_busy,
   input  logic md_start_e,
   input  logic exc_m,
   output logic stall_f,
   output logic stall_d,
   output logic stall_e,
   output logic stall_m,
   output logic flush_d,
   output logic flush_e,
   output logic flush_m,
   output logic drop_resp,
   output logic md_busy
);

   localparam int          CW     = (MD_CYCLES > 2) ? $clog2(MD_CYCLES) : 1;
   localparam logic [0:0]  c_IDLE = 1'b0;
   localparam logic [0:0]  c_MD   = 1'b1;

   logic [0:0]    r_state;
   logic [0:0]    w_state_nxt;
   logic [CW-1:0] r_md_cnt;
   logic [CW-1:0] w_md_cnt_nxt;
   logic          r_drop_pending;
   logic          w_drop_pending_nxt;
   logic          w_kill;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state        <= c_IDLE;
         r_md_cnt       <= '0;
         r_drop_pending <= 1'b0;
      end else begin
         r_state        <= w_state_nxt;
         r_md_cnt       <= w_md_cnt_nxt;
         r_drop_pending <= w_drop_pending_nxt;
      end
   end

   // Mul/div state advances even under dmem back-pressure; only an exception cancels it.
   always_comb begin
      w_state_nxt  = r_state;
      w_md_cnt_nxt = r_md_cnt;
      if (exc_m) begin
         w_state_nxt  = c_IDLE;
         w_md_cnt_nxt = '0;
      end else if (r_state == c_MD) begin
         if (r_md_cnt == '0) begin
            w_state_nxt = c_IDLE;
         end else begin
            w_md_cnt_nxt = r_md_cnt - CW'(1);
         end
      end else if (md_start_e) begin
         w_state_nxt  = c_MD;
         w_md_cnt_nxt = CW'(MD_CYCLES - 2);
      end
      w_drop_pending_nxt = (r_drop_pending & ~imem_resp) | (w_kill & imem_busy & ~imem_resp);
   end

   always_comb begin
      stall_f   = 1'b0;
      stall_d   = 1'b0;
      stall_e   = 1'b0;
      stall_m   = 1'b0;
      flush_d   = 1'b0;
      flush_e   = 1'b0;
      flush_m   = 1'b0;
      w_kill    = 1'b0;
      drop_resp = 1'b0;
      md_busy   = 1'b0;
      if (reset) begin
         drop_resp = r_drop_pending & imem_resp;
         md_busy   = (r_state == c_MD);
         if (exc_m) begin
            flush_d = 1'b1;
            flush_e = 1'b1;
            flush_m = 1'b1;
            w_kill  = 1'b1;
         end else if (dmem_busy) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
            stall_m = 1'b1;
         end else if ((r_state == c_MD) || md_start_e) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
            flush_m = 1'b1;
         end else if (load_use_d) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
         end else if (redirect_d) begin
            flush_d = 1'b1;
            w_kill  = 1'b1;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_pipeline_ctrl.sv
// =============================================================================
// Module  : tb_pipeline_ctrl
// Brief   : Scoreboard bench for pipeline_ctrl with a cycle-level reference model
// Revision: 1.0
// =============================================================================
`default_nettype none

module tb_pipeline_ctrl;

   localparam int MD = 4;

   logic clk;
   logic rst_n;
   logic redirect_d, load_use_d, imem_busy, imem_resp, dmem_busy, md_start_e, exc_m;
   logic stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_m, drop_resp, md_busy;

   pipeline_ctrl #(.MD_CYCLES(MD)) dut (
      .clk        (clk),
      .reset      (rst_n),
      .redirect_d (redirect_d),
      .load_use_d (load_use_d),
      .imem_busy  (imem_busy),
      .imem_resp  (imem_resp),
      .dmem_busy  (dmem_busy),
      .md_start_e (md_start_e),
      .exc_m      (exc_m),
      .stall_f    (stall_f),
      .stall_d    (stall_d),
      .stall_e    (stall_e),
      .stall_m    (stall_m),
      .flush_d    (flush_d),
      .flush_e    (flush_e),
      .flush_m    (flush_m),
      .drop_resp  (drop_resp),
      .md_busy    (md_busy)
   );

   typedef struct packed {
      int         cyc;
      logic [8:0] v;
   } exp_t;

   exp_t q[$];
   int   total = 0;
   int   bad   = 0;
   int   cyc_n = 0;

   // Reference state: cycles of E-hold still owed after the current one, and a pending drop.
   int   hold_left = 0;
   bit   drop      = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Input vector order: {exc, md_start, dmem_busy, imem_busy, imem_resp, load_use, redirect}
   function automatic logic [8:0] predict(input logic [6:0] v, input logic r, output bit kill);
      logic sf, sd, se, sm, fd, fe, fm, dr, mb;
      bit   busy;
      {sf, sd, se, sm, fd, fe, fm, dr, mb} = '0;
      kill = 0;
      busy = (hold_left > 0);
      if (r) begin
         dr = drop && v[2];
         mb = busy;
         if (v[6]) begin
            fd = 1; fe = 1; fm = 1; kill = 1;
         end else if (v[4]) begin
            sf = 1; sd = 1; se = 1; sm = 1;
         end else if (busy || v[5]) begin
            sf = 1; sd = 1; se = 1; fm = 1;
         end else if (v[1]) begin
            sf = 1; sd = 1; fe = 1;
         end else if (v[0]) begin
            fd = 1; kill = 1;
         end
      end
      return {sf, sd, se, sm, fd, fe, fm, dr, mb};
   endfunction

   task automatic advance(input logic [6:0] v, input logic r, input bit kill);
      if (!r) begin
         hold_left = 0;
         drop      = 0;
      end else begin
         if (v[6])                hold_left = 0;
         else if (hold_left > 0)  hold_left = hold_left - 1;
         else if (v[5])           hold_left = MD - 1;
         drop = (drop && !v[2]) || (kill && v[3] && !v[2]);
      end
   endtask

   task automatic cyc(input logic [6:0] v, input logic r);
      bit   kill;
      exp_t e;
      @(posedge clk);
      #1;
      rst_n = r;
      {exc_m, md_start_e, dmem_busy, imem_busy, imem_resp, load_use_d, redirect_d} = v;
      e.cyc = cyc_n;
      e.v   = predict(v, r, kill);
      q.push_back(e);
      advance(v, r, kill);
      cyc_n++;
   endtask

   // Reset dropped asynchronously partway through the cycle; outputs must vanish at once.
   task automatic async_rst(input logic [6:0] v);
      exp_t e;
      @(posedge clk);
      #1;
      {exc_m, md_start_e, dmem_busy, imem_busy, imem_resp, load_use_d, redirect_d} = v;
      #2;
      rst_n = 1'b0;
      e.cyc = cyc_n;
      e.v   = '0;
      q.push_back(e);
      advance(v, 1'b0, 0);
      cyc_n++;
   endtask

   initial begin : monitor
      exp_t       e;
      logic [8:0] act;
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            e   = q.pop_front();
            act = {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_m, drop_resp, md_busy};
            total++;
            if (act !== e.v) begin
               bad++;
               $display("FAIL outs@cyc%0d: got %b want %b (sf sd se sm fd fe fm drop mdb)",
                        e.cyc, act, e.v);
            end
         end
      end
   end

   initial begin : stim
      logic [6:0] v;
      rst_n = 1'b1;
      {exc_m, md_start_e, dmem_busy, imem_busy, imem_resp, load_use_d, redirect_d} = '0;
      #2 rst_n = 1'b0;

      cyc(7'h7F, 1'b0);
      cyc(7'h7F, 1'b0);

      // Mul/div hold: t=0..1 idle, start at t=2, watch through t=6
      cyc(7'h00, 1'b1);
      cyc(7'h00, 1'b1);
      cyc(7'b0100000, 1'b1);
      repeat (5) cyc(7'h00, 1'b1);

      // Load-use beats redirect, then redirect alone
      cyc(7'b0000011, 1'b1);
      cyc(7'b0000001, 1'b1);
      cyc(7'h00, 1'b1);

      // Redirect with fetch in flight, response three cycles later
      cyc(7'b0001001, 1'b1);
      cyc(7'b0001000, 1'b1);
      cyc(7'b0001000, 1'b1);
      cyc(7'b0000100, 1'b1);
      cyc(7'b0000100, 1'b1);
      // Redirect coinciding with the response
      cyc(7'b0001101, 1'b1);
      cyc(7'b0000100, 1'b1);

      // Exception on second MD cycle with dmem busy
      cyc(7'b0100000, 1'b1);
      cyc(7'b1010000, 1'b1);
      cyc(7'h00, 1'b1);
      cyc(7'h00, 1'b1);

      // dmem_busy overlapping MD for three cycles
      cyc(7'b0100000, 1'b1);
      cyc(7'b0010000, 1'b1);
      cyc(7'b0010000, 1'b1);
      cyc(7'b0010000, 1'b1);
      cyc(7'h00, 1'b1);
      cyc(7'h00, 1'b1);

      // md_start under dmem_busy in IDLE still enters MD
      cyc(7'b0110000, 1'b1);
      repeat (4) cyc(7'h00, 1'b1);

      // Asynchronous reset mid-MD with a drop pending, then a response after release
      cyc(7'b0001001, 1'b1);
      cyc(7'b0101000, 1'b1);
      cyc(7'b0001000, 1'b1);
      async_rst(7'b0001000);
      cyc(7'b0001000, 1'b0);
      cyc(7'b0000100, 1'b1);
      cyc(7'h00, 1'b1);

      // Randomised traffic with occasional resets
      for (int i = 0; i < 400; i++) begin
         v[6] = ($urandom_range(0, 99) < 5);
         v[5] = ($urandom_range(0, 99) < 10);
         v[4] = ($urandom_range(0, 99) < 20);
         v[3] = ($urandom_range(0, 99) < 50);
         v[2] = ($urandom_range(0, 99) < 30);
         v[1] = ($urandom_range(0, 99) < 20);
         v[0] = ($urandom_range(0, 99) < 30);
         if ($urandom_range(0, 199) == 0) async_rst(v);
         else cyc(v, ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1);
      end

      cyc(7'h00, 1'b1);
      repeat (3) @(posedge clk);
      total++;
      if (q.size() != 0) begin
         bad++;
         $display("FAIL scoreboard_drain: got %0d entries left want 0", q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central stall/flush scheduler for the five-stage pipeline. It collects decode-stage redirect and load-use hazards, data-memory back-pressure, multi-cycle mul/div occupancy in execute, and memory-stage exceptions. From these it produces per-stage stall and flush controls. It also tracks wrong-path instruction fetches that are still in flight when a redirect occurs, so fetch can discard their responses.

## Interface
- MD_CYCLES, 32, cycles the execute stage is held for one mul/div op (legal ≥2)
- CW, $clog2(MD_CYCLES), counter width (derived, not overridden)

- clk  in  1  clock, all state updates on posedge
- reset  in  1  asynchronous, active-low (0 = in reset)
- redirect_d  in  1  decode resolved taken branch / jump / jr this cycle
- load_use_d  in  1  decode source depends on a load currently in E
- imem_busy  in  1  instruction-fetch request outstanding (issued, not yet answered)
- imem_resp  in  1  instruction-fetch response valid this cycle
- dmem_busy  in  1  data memory cannot complete the M-stage access this cycle
- md_start_e  in  1  mul/div instruction present in E, first cycle
- exc_m  in  1  exception/trap taken in M this cycle
- stall_f, stall_d, stall_e, stall_m  out  1 each  hold stage register
- flush_d, flush_e, flush_m  out  1 each  load bubble into stage register
- drop_resp  out  1  fetch must discard current imem response
- md_busy  out  1  mul/div hold in progress (state MD)

## Operation
- State: fsm ∈ {IDLE, MD}, md_cnt[CW-1:0], drop_pending (1 bit).
- Outputs are combinational from state and inputs. Outputs not driven by the rules below are 0.
- Priority per cycle, highest first; the first matching rule defines all stall/flush outputs:
  1. exc_m: flush_d = flush_e = flush_m = 1, no stalls. fsm→IDLE, md_cnt→0 (mul/div cancelled).
  2. dmem_busy: stall_f = stall_d = stall_e = stall_m = 1. fsm/md_cnt continue to update per rules 3/4.
  3. fsm==MD: stall_f = stall_d = stall_e = 1, flush_m = 1. md_cnt decrements. When md_cnt==0 this cycle, fsm→IDLE.
  4. fsm==IDLE & md_start_e: same outputs as rule 3. fsm→MD, md_cnt→MD_CYCLES-2. E is held MD_CYCLES cycles in total.
  5. load_use_d: stall_f = stall_d = 1, flush_e = 1. Any redirect_d this cycle is ignored; decode re-presents it.
  6. redirect_d: flush_d = 1 (kills the wrong-path instruction fetched behind the branch).
- md_start_e under dmem_busy in IDLE still enters MD (rule 4 state update applies). Outputs are per rule 2.
- kill = rule 1 fires, or rule 6 fires.
- drop_pending_next = (drop_pending & ~imem_resp) | (kill & imem_busy & ~imem_resp).
- drop_resp = drop_pending & imem_resp.
- A kill coinciding with imem_resp does not set drop_pending. That response is removed by flush_d / flush_* instead.
- At most one fetch is outstanding, so drop_pending is a single flag. A second kill while it is set leaves it set.
- md_busy = (fsm==MD).

## Timing
- While reset==0: fsm=IDLE, md_cnt=0, drop_pending=0. All outputs are forced to 0 regardless of inputs.
- Deassertion takes effect at the first posedge with reset==1.
- Zero-latency control: outputs respond in the same cycle as their inputs. State changes are visible the cycle after the edge.
- Mul/div: md_start_e in cycle t yields stall_e=1 in cycles t .. t+MD_CYCLES-1 and md_busy=1 in t+1 .. t+MD_CYCLES-1. In cycle t+MD_CYCLES, fsm is IDLE and E advances.
- Exception mid-MD cancels immediately: md_busy=0 next cycle.
- drop_resp is asserted exactly once per recorded wrong-path fetch, on its response cycle.
- Reset mid-operation clears MD and drop_pending. A response arriving after reset is not dropped.

## Test plan
- MD_CYCLES=4, md_start_e pulse at t=2 → stall_e=1 for t=2..5; flush_m=1 for t=2..5; md_busy=1 for t=3..5; all 0 at t=6.
- load_use_d and redirect_d both high for 1 cycle → stall_f=stall_d=flush_e=1, flush_d=0; next cycle redirect_d alone → flush_d=1 only.
- redirect_d with imem_busy=1, imem_resp=0 → flush_d=1. Response arrives 3 cycles later → drop_resp=1 for that one cycle, then 0. A redirect coinciding with imem_resp → drop_resp stays 0.
- exc_m at cycle 2 of an MD hold, with dmem_busy=1 → flush_d=flush_e=flush_m=1, all stalls 0; md_busy=0 next cycle.
- dmem_busy held 3 cycles during MD (MD_CYCLES=4) → all four stalls=1 during overlap; MD still exits after 4 total cycles.
- reset driven low asynchronously mid-MD with drop_pending=1 → all outputs 0 immediately. After release, imem_resp → drop_resp=0 and md_busy=0.
